// File: rtl/uart_pkg.sv
// Shared frame-format constants, FSM state encodings and helper functions
// for the FIFO-buffered UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int clk_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Data narrower than 8 bits is zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word fall-through FIFO with a separate occupancy counter.
// Push when full and pop when empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with TX/RX FIFOs. Fabric side: push on tx_valid && tx_ready,
// pop on rx_valid && rx_ready; a transfer happens on the clock edge where both are high.
module uart_fifo_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        tx_busy,
  output logic                        uart_tx,
  input  logic                        uart_rx
);

  localparam int CPB   = clk_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CPB / 2);

  logic [DATA_BITS-1:0]   tx_head;
  logic                   tx_full, tx_empty, tx_pop;
  logic [DATA_BITS+1:0]   rx_head, rx_entry;
  logic                   rx_full, rx_empty, rx_push;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
    .pop_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_entry), .pop(rx_ready),
    .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_ready      = !tx_full;
  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_head[DATA_BITS-1:0];
  assign rx_parity_err = rx_head[DATA_BITS];
  assign rx_frame_err  = rx_head[DATA_BITS+1];

  tx_state_t            tx_state, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
  logic [2:0]           tx_idx, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_par, tx_par_d, tx_line_d, tx_load, tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_shift <= tx_shift_d;
      tx_par   <= tx_par_d;
      uart_tx  <= tx_line_d;
    end
  end

  // tx_line_d is the level for the bit that begins on the next edge.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt + 1'b1;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    tx_line_d  = uart_tx;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        tx_load   = !tx_empty;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
        tx_line_d  = tx_shift[0];
      end
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift >> 1;
        if (tx_idx == 3'(DATA_BITS - 1)) begin
          if (PARITY != PARITY_NONE) begin
            tx_state_d = TX_PARITY;
            tx_line_d  = tx_par;
          end else begin
            tx_state_d = TX_STOP;
            tx_idx_d   = '0;
            tx_line_d  = 1'b1;
          end
        end else begin
          tx_idx_d  = tx_idx + 1'b1;
          tx_line_d = tx_shift[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_idx_d   = '0;
        tx_line_d  = 1'b1;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_idx == 3'(STOP_BITS - 1)) begin
          tx_load    = !tx_empty;
          tx_state_d = TX_IDLE;
        end else begin
          tx_idx_d = tx_idx + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_head;
      tx_par_d   = parity_bit(8'(tx_head), PARITY);
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_line_d  = 1'b0;
    end
  end

  rx_state_t            rx_state, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_d;
  logic [2:0]           rx_idx, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_perr, rx_perr_d, rx_bit_end;
  logic                 rx_meta, rx_sync, rx_prev;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_entry   = {!rx_sync, rx_perr, rx_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_perr     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      rx_state    <= rx_state_d;
      rx_cnt      <= rx_cnt_d;
      rx_idx      <= rx_idx_d;
      rx_shift    <= rx_shift_d;
      rx_perr     <= rx_perr_d;
      rx_overflow <= rx_push && rx_full;
    end
  end

  // After the mid-start sample the counter restarts, so later samples land on bit_end.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_idx_d   = rx_idx;
    rx_shift_d = rx_shift;
    rx_perr_d  = rx_perr;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_sync) begin
          rx_state_d = RX_START;
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: if (rx_cnt == BIT_MID) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
        if (rx_idx == 3'(DATA_BITS - 1))
          rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
        else
          rx_idx_d = rx_idx + 1'b1;
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_perr_d  = (rx_sync != parity_bit(8'(rx_shift), PARITY));
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_push    = 1'b1;
        rx_state_d = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Bench for uart_fifo_transceiver: default-rate TX framing, glitch/break on RX,
// 7E1 loopback, odd-parity injection with overflow, and mid-frame reset.
module tb_uart_fifo_transceiver;

  localparam int CPB_A = 868;
  localparam int CPB_C = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ovf_cnt_c = 0;

  always #5 clk = ~clk;

  // dut_a: defaults, 8N1 at 868 clocks/bit
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic       tx_valid_a = 1'b0, tx_ready_a, rx_frame_err_a, rx_parity_err_a, rx_valid_a;
  logic       rx_ready_a = 1'b0, rx_overflow_a, tx_busy_a, uart_tx_a, rx_line_a = 1'b1;
  logic [4:0] tx_count_a, rx_count_a;

  // dut_b: 7E1 at 16 clocks/bit, serial loopback
  logic [6:0] tx_data_b = '0, rx_data_b;
  logic       tx_valid_b = 1'b0, tx_ready_b, rx_frame_err_b, rx_parity_err_b, rx_valid_b;
  logic       rx_ready_b = 1'b1, rx_overflow_b, tx_busy_b, uart_tx_b;
  logic [4:0] tx_count_b, rx_count_b;

  // dut_c: 8O1 at 16 clocks/bit, RX driven by the bench
  logic [7:0] tx_data_c = '0, rx_data_c;
  logic       tx_valid_c = 1'b0, tx_ready_c, rx_frame_err_c, rx_parity_err_c, rx_valid_c;
  logic       rx_ready_c = 1'b1, rx_overflow_c, tx_busy_c, uart_tx_c, rx_line_c = 1'b1;
  logic [4:0] tx_count_c, rx_count_c;

  logic       exp_bit_q[$];
  logic [9:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  logic [9:0] exp_q_c[$];

  uart_fifo_transceiver dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_frame_err(rx_frame_err_a), .rx_parity_err(rx_parity_err_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_overflow(rx_overflow_a),
    .tx_count(tx_count_a), .rx_count(rx_count_a), .tx_busy(tx_busy_a),
    .uart_tx(uart_tx_a), .uart_rx(rx_line_a)
  );

  uart_fifo_transceiver #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_frame_err(rx_frame_err_b), .rx_parity_err(rx_parity_err_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_overflow(rx_overflow_b),
    .tx_count(tx_count_b), .rx_count(rx_count_b), .tx_busy(tx_busy_b),
    .uart_tx(uart_tx_b), .uart_rx(uart_tx_b)
  );

  uart_fifo_transceiver #(.CLK_HZ(1_600_000), .BAUD(100_000), .PARITY(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .rx_data(rx_data_c), .rx_frame_err(rx_frame_err_c), .rx_parity_err(rx_parity_err_c),
    .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_overflow(rx_overflow_c),
    .tx_count(tx_count_c), .rx_count(rx_count_c), .tx_busy(tx_busy_c),
    .uart_tx(uart_tx_c), .uart_rx(rx_line_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame_bits(input logic [7:0] data);
    exp_bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(data[i]);
    exp_bit_q.push_back(1'b1);
  endtask

  // Drives one 8O1 frame on dut_c's RX pin; called and returns at posedge+1.
  task automatic send_frame_c(input logic [7:0] data, input logic par);
    logic [10:0] bits;
    bits = {1'b1, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_line_c = bits[i];
      repeat (CPB_C) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rx_valid_a && rx_ready_a) begin
      if (exp_q_a.size() == 0) check_eq("rx_a_unexpected", exp_q_a.size(), 1);
      else check_eq("rx_a_entry", {rx_frame_err_a, rx_parity_err_a, rx_data_a}, exp_q_a.pop_front());
    end
    if (rst_n && rx_valid_b && rx_ready_b) begin
      if (exp_q_b.size() == 0) check_eq("rx_b_unexpected", exp_q_b.size(), 1);
      else check_eq("rx_b_entry", {rx_frame_err_b, rx_parity_err_b, rx_data_b}, exp_q_b.pop_front());
    end
    if (rst_n && rx_valid_c && rx_ready_c) begin
      if (exp_q_c.size() == 0) check_eq("rx_c_unexpected", exp_q_c.size(), 1);
      else check_eq("rx_c_entry", {rx_frame_err_c, rx_parity_err_c, rx_data_c}, exp_q_c.pop_front());
    end
    if (rx_overflow_c) ovf_cnt_c++;
  end

  initial begin
    logic [7:0] b;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_uart_tx", uart_tx_a, 1);
    check_eq("rst_tx_ready", tx_ready_a, 1);
    check_eq("rst_rx_valid", rx_valid_a, 0);
    check_eq("rst_tx_count", tx_count_a, 0);
    check_eq("rst_rx_count", rx_count_a, 0);
    check_eq("rst_rx_overflow", rx_overflow_a, 0);
    check_eq("rst_tx_busy", tx_busy_a, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // two back-to-back 8N1 frames, sampled mid-bit on a fixed grid
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h61;
    push_frame_bits(8'h61);
    @(posedge clk);
    #1;
    check_eq("tx_idle_before_pop", uart_tx_a, 1);
    check_eq("tx_count_after_push", tx_count_a, 1);
    tx_data_a = 8'h62;
    push_frame_bits(8'h62);
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    check_eq("tx_start_latency", uart_tx_a, 0);
    check_eq("tx_count_push_pop", tx_count_a, 1);
    check_eq("tx_busy_frame", tx_busy_a, 1);
    repeat (CPB_A / 2) @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) begin
        repeat (CPB_A) @(posedge clk);
        #1;
      end
      check_eq($sformatf("tx_bit%0d", k), uart_tx_a, exp_bit_q.pop_front());
    end
    repeat (CPB_A - CPB_A / 2 - 1) @(posedge clk);
    #1;
    check_eq("tx_busy_last_stop", tx_busy_a, 1);
    @(posedge clk);
    #1;
    check_eq("tx_busy_fall", tx_busy_a, 0);
    check_eq("tx_line_idle", uart_tx_a, 1);

    // 300-cycle glitch is rejected at the mid-start sample
    rx_line_a = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rx_line_a = 1'b1;
    repeat (2 * CPB_A) @(posedge clk);
    #1;
    check_eq("glitch_no_push", rx_count_a, 0);

    // 12 bit-times of break: one framing-error entry, nothing more
    exp_q_a.push_back({1'b1, 1'b0, 8'h00});
    rx_line_a = 1'b0;
    repeat (12 * CPB_A) @(posedge clk);
    #1;
    check_eq("break_one_entry", rx_count_a, 1);
    rx_line_a = 1'b1;
    repeat (2 * CPB_A) @(posedge clk);
    #1;
    check_eq("break_released_count", rx_count_a, 1);
    rx_ready_a = 1'b1;
    for (int i = 0; i < 20 && exp_q_a.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("rx_a_drained", exp_q_a.size(), 0);
    check_eq("rx_a_empty", rx_valid_a, 0);

    // 7E1 loopback
    tx_valid_b = 1'b1;
    tx_data_b  = 7'h55;
    exp_q_b.push_back({1'b0, 1'b0, 7'h55});
    @(posedge clk);
    #1;
    tx_valid_b = 1'b0;
    for (int i = 0; i < 400 && exp_q_b.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("rx_b_drained", exp_q_b.size(), 0);

    // 0xA5 with wrong odd parity
    exp_q_c.push_back({1'b0, 1'b1, 8'hA5});
    send_frame_c(8'hA5, ^8'hA5);
    for (int i = 0; i < 40 && exp_q_c.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("rx_c_parity_drained", exp_q_c.size(), 0);

    // 17 bytes into a 16-deep RX FIFO with no pops
    rx_ready_c = 1'b0;
    for (int n = 0; n < 17; n++) begin
      b = 8'($urandom_range(0, 255));
      if (n < 16) exp_q_c.push_back({1'b0, 1'b0, b});
      send_frame_c(b, ~(^b));
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("ovf_rx_count", rx_count_c, 16);
    check_eq("ovf_pulses", ovf_cnt_c, 1);
    rx_ready_c = 1'b1;
    for (int i = 0; i < 60 && exp_q_c.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ovf_drained", exp_q_c.size(), 0);
    check_eq("ovf_17th_dropped", rx_valid_c, 0);

    // reset during DATA of the second queued frame (second byte 0x00 keeps the line low)
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h5A;
    @(posedge clk);
    #1;
    tx_data_a = 8'h00;
    @(posedge clk);
    #1;
    tx_data_a = 8'h3C;
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    repeat (13 * CPB_A + CPB_A / 2 - 1) @(posedge clk);
    #1;
    check_eq("rst_mid_line_low", uart_tx_a, 0);
    check_eq("rst_mid_count_before", tx_count_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_uart_tx", uart_tx_a, 1);
    check_eq("rst_mid_tx_count", tx_count_a, 0);
    check_eq("rst_mid_tx_ready", tx_ready_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
